// File: rtl/shnorm_pkg.sv
// shnorm_pkg: definitions shared by the iterative shift normalizer.
//   state_t        FSM states of the normalizer (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  default operand/result width
//   DIR_LEFT/RIGHT encodings of the dir input
package shnorm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : shnorm_pkg

// File: rtl/shift_normalizer.sv
// shift_normalizer: iterative normalizer, one bit position per clock.
// Shifts the accepted operand until its leading '1' sits at bit WIDTH-1
// (or, for right normalization, its lowest '1' sits at bit 0) and reports
// the number of positions shifted. A zero operand returns shift_count=WIDTH
// and zero_flag=1.
//
// Optional feature: define SHNORM_RIGHT_EN to honour dir (right / trailing-
// zero normalization). Without it dir is ignored and treated as left.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start_valid/start_ready  operand handshake (ready only in IDLE)
//   operand, dir             sampled on the accept edge only
//   res_valid/res_ready      result handshake (valid only in DONE)
//   norm_value, shift_count, zero_flag  result, held stable while in DONE
module shift_normalizer
  import shnorm_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic             dir,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] norm_value,
  output logic [CNT_W-1:0] shift_count,
  output logic             zero_flag
);

  state_t           state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [CNT_W-1:0] count_reg;
  logic             zero_reg;

  logic             accept_dir;  // direction used for the accept-time check
  logic             run_dir;     // direction used while shifting
  logic [WIDTH-1:0] step_value;  // working value after one more shift

`ifdef SHNORM_RIGHT_EN
  logic dir_reg;
  assign accept_dir = dir;
  assign run_dir    = dir_reg;
  assign step_value = (run_dir == DIR_RIGHT) ? (work_reg >> 1) : (work_reg << 1);
`else
  // dir stays on the port list but has no function in this build.
  logic unused_dir;
  assign unused_dir = dir;
  assign accept_dir = DIR_LEFT;
  assign run_dir    = DIR_LEFT;
  assign step_value = work_reg << 1;
`endif

  // A value is normalized when the bit the shift moves towards is set.
  function automatic logic is_norm(input logic [WIDTH-1:0] v, input logic d);
    return (d == DIR_RIGHT) ? v[0] : v[WIDTH-1];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      count_reg <= '0;
      zero_reg  <= 1'b0;
`ifdef SHNORM_RIGHT_EN
      dir_reg   <= DIR_LEFT;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_valid) begin
            work_reg  <= operand;
            count_reg <= '0;
            zero_reg  <= 1'b0;
`ifdef SHNORM_RIGHT_EN
            dir_reg   <= dir;
`endif
            if (operand == '0) begin
              // Nothing to find: report the full width as the shift amount.
              count_reg <= CNT_W'(WIDTH);
              zero_reg  <= 1'b1;
              state_reg <= DONE;
            end else if (is_norm(operand, accept_dir)) begin
              state_reg <= DONE;
            end else begin
              state_reg <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_reg  <= step_value;
          count_reg <= count_reg + CNT_W'(1);
          // Check the value being written, so DONE is reached on the same
          // edge as the final shift.
          if (is_norm(step_value, run_dir)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_reg == IDLE);
  assign res_valid   = (state_reg == DONE);
  assign norm_value  = work_reg;
  assign shift_count = count_reg;
  assign zero_flag   = zero_reg;

endmodule : shift_normalizer

// File: doc/shift_normalizer.md
# shift_normalizer

Iterative normalizer for the multicycle ALU datapath: the inverse of the left/right shift path. It takes an operand and shifts it one bit per cycle until the leading '1' reaches bit WIDTH-1. It returns the normalized value together with the shift amount that was applied, which is the leading-zero count. The block sits beside the shift path in the ALU, uses a valid/ready handshake on both sides, and is used for count-leading-zeros style results and for normalization.

## Interface
- WIDTH, 32, operand and result width; must be ≥ 2.
- CNT_W, $clog2(WIDTH+1) (6 for WIDTH=32), width of shift_count; localparam, not overridable.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- start_valid  input  1  operand valid.
- start_ready  output  1  block can accept an operand.
- operand  input  WIDTH  value to normalize.
- dir  input  1  0 = left normalize (leading zeros), 1 = right normalize (trailing zeros); only meaningful with the Configuration macro defined.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts the result.
- norm_value  output  WIDTH  normalized value.
- shift_count  output  CNT_W  number of bit positions shifted.
- zero_flag  output  1  operand was zero.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - Accept on start_valid&&start_ready: load the working register with operand, count=0, latch dir.
  - operand==0: go to DONE with norm_value=0, shift_count=WIDTH, zero_flag=1.
  - Operand already normalized (left: bit WIDTH-1 set; right: bit 0 set): go to DONE with count=0.
  - Otherwise go to SHIFT.
- SHIFT:
  - Each cycle, logical shift by 1 (left: <<1; right: >>1, zero-filled) and count+1.
  - If the shifted value is normalized, go to DONE on the same edge.
  - Count never exceeds WIDTH-1 for a non-zero operand.
- DONE:
  - res_valid=1.
  - norm_value, shift_count and zero_flag are held stable until res_valid&&res_ready; on that handshake go to IDLE.
- start_ready=0 in SHIFT and DONE. A new operand is never accepted in the same cycle a result is consumed.
- Inputs are sampled only on the accept edge. Changes to operand or dir afterwards have no effect.
- Width rule: shift_count is zero-extended. The value WIDTH is representable only because CNT_W = $clog2(WIDTH+1).

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, start_ready=1, res_valid=0, norm_value=0, shift_count=0, zero_flag=0.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation immediately. No result is emitted after release.
- Latency, with L = number of zeros ahead of the first '1':
  - The accept edge is E0.
  - res_valid rises after edge E0+L.
  - For L=0 and for the zero operand, res_valid is high in the cycle right after E0.
- Throughput: one operation per L+2 cycles at best, including the IDLE cycle.
- res_ready held low: stall in DONE indefinitely, outputs unchanged.
- res_ready has no effect outside DONE.

## Configuration
- SHNORM_RIGHT_EN defined: dir is honoured, so both left (leading-zero) and right (trailing-zero) normalization are available.
- SHNORM_RIGHT_EN undefined:
  - dir is ignored and treated as 0.
  - Right-shift logic and the latched dir flop are removed.
  - The port list is unchanged.

## Structure
- Shared package shnorm_pkg holds:
  - the state enum: IDLE, SHIFT, DONE;
  - the default WIDTH constant;
  - the direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1.
- Single module. No sub-module: the one-bit step shifter is inline.

## Test plan
- Left normalize, operand=0x0000_0001, dir=0:
  - res_valid after edge E0+31;
  - norm_value=0x8000_0000, shift_count=31, zero_flag=0.
- Operand=0x8000_0000:
  - res_valid in the cycle after E0;
  - norm_value=0x8000_0000, shift_count=0.
- Operand=0x0000_0000: norm_value=0, shift_count=32, zero_flag=1, res_valid in the cycle after E0.
- Backpressure, operand=0x0001_0000:
  - shift_count=15, norm_value=0x8000_0000;
  - hold res_ready=0 for 5 cycles: outputs stable, start_ready=0, and a second start_valid is not accepted until after the result handshake.
- With SHNORM_RIGHT_EN, operand=0x0000_0100, dir=1:
  - shift_count=8, norm_value=0x0000_0001.
  - Without the macro, the same stimulus gives shift_count=23, norm_value=0x8000_0000.
- Assert rst_n=0 during SHIFT for operand 0x0000_0001:
  - outputs return to reset values asynchronously;
  - after release, no res_valid appears, start_ready=1, and a fresh operand 0x4000_0000 yields shift_count=1.
